// File: rtl/melody_player.sv
// Melody sequencer: steps through a small RAM of {dur, note} entries and plays each
// entry as a square wave, preceded by a silent articulation gap.
module melody_player #(
    parameter int  DEPTH      = 64,
    parameter int  UNIT_CYC   = 12_500_000,
    parameter int  GAP_CYC    = 2_500_000,
    parameter int  TONE_SHIFT = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          loop_en,
    output logic          pwm,
    output logic          busy,
    output logic          playing,
    output logic [AW-1:0] note_idx,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, GAP, TONE, PAUSED} state_t;
    localparam logic [4:0] END_MARK = 5'd31;

    state_t        state_q, state_d, ret_q, ret_d, phase_d;
    logic [AW-1:0] idx_q, idx_d, idx_next;
    logic [31:0]   dur_q, dur_d, tcnt_q, tcnt_d;
    logic          pwm_q, pwm_d, done_q, done_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    cur_entry;
    logic [4:0]    cur_note;
    logic          cur_is_tone, last_note, unused_rsvd;
    logic [31:0]   half_per, tone_len;

    function automatic logic [31:0] half_period(input logic [4:0] note);
        logic [31:0] base;
        logic [31:0] h;
        case (note)
            5'd1:    base = 32'd190840;
            5'd2:    base = 32'd170068;
            5'd3:    base = 32'd151515;
            5'd4:    base = 32'd143266;
            5'd5:    base = 32'd127551;
            5'd6:    base = 32'd113636;
            5'd7:    base = 32'd101215;
            5'd8:    base = 32'd95602;
            5'd9:    base = 32'd85179;
            5'd10:   base = 32'd75873;
            5'd11:   base = 32'd71633;
            5'd12:   base = 32'd63776;
            5'd13:   base = 32'd56818;
            5'd14:   base = 32'd50607;
            5'd15:   base = 32'd47801;
            5'd16:   base = 32'd42590;
            5'd17:   base = 32'd37937;
            5'd18:   base = 32'd35817;
            5'd19:   base = 32'd31888;
            5'd20:   base = 32'd28409;
            5'd21:   base = 32'd25304;
            default: base = 32'd1;
        endcase
        h = base >> TONE_SHIFT;
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

    // Melody RAM: no reset so contents survive rst_n; only writable while idle.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign cur_entry   = mem_q[idx_q];
    assign cur_note    = cur_entry[4:0];
    assign unused_rsvd = cur_entry[5];
    assign cur_is_tone = (cur_note != 5'd0) && (cur_note <= 5'd21);
    assign half_per    = half_period(cur_note);
    assign tone_len    = (32'(UNIT_CYC) << cur_entry[7:6]) - 32'(GAP_CYC);
    assign idx_next    = idx_q + AW'(1);
    assign last_note   = (idx_q == AW'(DEPTH - 1)) || (mem_q[idx_next][4:0] == END_MARK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            idx_q   <= '0;
            dur_q   <= '0;
            tcnt_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            tcnt_q  <= tcnt_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        phase_d = state_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        tcnt_d  = tcnt_q;
        pwm_d   = pwm_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    idx_d  = '0;
                    dur_d  = '0;
                    tcnt_d = '0;
                    pwm_d  = 1'b0;
                    if (mem_q[0][4:0] == END_MARK) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP, TONE: begin
                if (state_q == GAP) begin
                    if (dur_q == 32'(GAP_CYC - 1)) begin
                        phase_d = TONE;
                        dur_d   = '0;
                        tcnt_d  = '0;
                        pwm_d   = 1'b0;
                    end else begin
                        dur_d = dur_q + 32'd1;
                    end
                end else begin
                    if (tcnt_q == half_per - 32'd1) begin
                        tcnt_d = '0;
                        pwm_d  = ~pwm_q;
                    end else begin
                        tcnt_d = tcnt_q + 32'd1;
                    end
                    if (dur_q == tone_len - 32'd1) begin
                        dur_d  = '0;
                        tcnt_d = '0;
                        pwm_d  = 1'b0;
                        if (!last_note) begin
                            idx_d   = idx_next;
                            phase_d = GAP;
                        end else if (loop_en) begin
                            idx_d   = '0;
                            phase_d = GAP;
                        end else begin
                            phase_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q + 32'd1;
                    end
                end
                // The cycle that samples pause still counts; the pause then holds the next phase.
                if (pause && phase_d != IDLE) begin
                    state_d = PAUSED;
                    ret_d   = phase_d;
                end else begin
                    state_d = phase_d;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = ret_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            dur_d   = '0;
            tcnt_d  = '0;
            pwm_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        playing  = (state_q == TONE) && cur_is_tone;
        pwm      = (state_q == TONE) && cur_is_tone && pwm_q;
        note_idx = idx_q;
        done     = done_q;
    end
endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: a note-level timing model checked every cycle, plus
// directed scenarios with hand-computed sample points.
module tb_melody_player;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int UNIT  = 1000;
    localparam int GAP   = 100;
    localparam int SHIFT = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic          pwm, busy, playing, done;
    logic [AW-1:0] note_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    melody_player #(.DEPTH(DEPTH), .UNIT_CYC(UNIT), .GAP_CYC(GAP), .TONE_SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
        .pwm(pwm), .busy(busy), .playing(playing), .note_idx(note_idx), .done(done)
    );

    // Model: position inside a note is the count t of elapsed unpaused cycles;
    // outputs follow from t by closed-form arithmetic.
    typedef struct packed {
        logic active;
        logic paused;
        logic done;
        int   idx;
        int   t;
    } mstate_t;

    mstate_t    m = '0;
    logic [7:0] m_mem [DEPTH];
    int base_tab [0:21] = '{0, 190840, 170068, 151515, 143266, 127551, 113636, 101215,
                            95602, 85179, 75873, 71633, 63776, 56818, 50607,
                            47801, 42590, 37937, 35817, 31888, 28409, 25304};

    function automatic int hp(input int note);
        int h;
        h = base_tab[note] >> SHIFT;
        return (h < 1) ? 1 : h;
    endfunction

    function automatic mstate_t step(input mstate_t s);
        mstate_t n;
        n = s;
        n.done = 1'b0;
        if (!s.active) begin
            if (start && !stop) begin
                n.idx = 0;
                if (m_mem[0][4:0] == 5'd31) n.done = 1'b1;
                else begin
                    n.active = 1'b1;
                    n.paused = 1'b0;
                    n.t      = 0;
                end
            end
        end else if (stop) begin
            n.active = 1'b0;
            n.paused = 1'b0;
            n.idx    = 0;
            n.t      = 0;
        end else if (s.paused) begin
            if (!pause) n.paused = 1'b0;
        end else begin
            n.t = s.t + 1;
            if (n.t == (UNIT << m_mem[s.idx][7:6])) begin
                n.t = 0;
                if (s.idx == DEPTH - 1 || m_mem[s.idx + 1][4:0] == 5'd31) begin
                    if (loop_en) n.idx = 0;
                    else begin
                        n.active = 1'b0;
                        n.done   = 1'b1;
                    end
                end else begin
                    n.idx = s.idx + 1;
                end
            end
            if (pause && n.active) n.paused = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [6:0] expect_out(input mstate_t s);
        int   nt;
        logic play, pw;
        nt   = int'(m_mem[s.idx][4:0]);
        play = s.active && !s.paused && (s.t >= GAP) && (nt >= 1) && (nt <= 21);
        pw   = 1'b0;
        if (play) pw = (((s.t - GAP) / hp(nt)) % 2) == 1;
        return {pw, s.active, play, s.done, s.idx[AW-1:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
        end else begin
            m <= step(m);
            if (!m.active && wr_en) m_mem[wr_addr] <= wr_data;
        end
    end

    initial begin
        logic [6:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            exp_v = expect_out(m);
            act_v = {pwm, busy, playing, done, note_idx};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got pwm,busy,playing,done,idx=%b want %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int pw [8200];
    int pl [8200];
    int bz [8200];
    int ix [8200];

    // Starts a playback and records outputs per cycle; k=0 is the first cycle after start is taken.
    task automatic play_record(input int limit, input int pause_at, input int pause_len,
                               input int stop_at, input int hit_at, output int done_at);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        done_at = -1;
        for (int k = 0; k < limit; k++) begin
            pw[k] = int'(pwm);
            pl[k] = int'(playing);
            bz[k] = int'(busy);
            ix[k] = int'(note_idx);
            if (done) begin
                done_at = k;
                break;
            end
            if (k == pause_at) pause = 1'b1;
            if (k == pause_at + pause_len) pause = 1'b0;
            stop = (k == stop_at);
            if (k == hit_at) begin
                wr_en   = 1'b1;
                wr_addr = AW'(1);
                wr_data = 8'h1F;
                start   = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        pause = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        $display("play done_at=%0d", done_at);
    endtask

    task automatic load_basic();
        wr(0, 8'h08);
        wr(1, 8'h49);
        for (int a = 2; a < DEPTH; a++) wr(a, 8'h1F);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", int'({pwm, busy, playing, done, note_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-note melody: mid do (H=93) one unit, mid re (H=83) two units.
        load_basic();
        play_record(4000, -1, 0, -1, -1, d);
        check("basic_done_at", d, 3000);
        check("basic_gap_silent", pw[99], 0);
        check("basic_play_gap", pl[99], 0);
        check("basic_play_tone", pl[100], 1);
        check("n0_pre_toggle", pw[192], 0);
        check("n0_first_high", pw[193], 1);
        check("n0_high_end", pw[285], 1);
        check("n0_low_again", pw[286], 0);
        check("n0_last_cycle", pw[999], 1);
        check("n1_gap", pw[1000], 0);
        check("n1_idx", ix[1000], 1);
        check("n1_pre_toggle", pw[1182], 0);
        check("n1_first_high", pw[1183], 1);
        check("n1_high_end", pw[1265], 1);
        check("n1_low_again", pw[1266], 0);
        check("busy_last_tone", bz[2999], 1);
        check("busy_at_done", bz[3000], 0);

        // Looping, then stop while pwm is high.
        loop_en = 1'b1;
        play_record(3300, -1, 0, 3200, -1, d);
        loop_en = 1'b0;
        check("loop_no_done", d, -1);
        check("loop_idx_before", ix[2999], 1);
        check("loop_idx_wrap", ix[3000], 0);
        check("loop_busy_wrap", bz[3000], 1);
        check("loop_gap_silent", pl[3099], 0);
        check("loop_replay", pl[3100], 1);
        check("stop_pwm_before", pw[3200], 1);
        check("stop_busy", bz[3201], 0);
        check("stop_pwm", pw[3201], 0);
        check("stop_idx", ix[3201], 0);

        // 500-cycle pause in the middle of the first tone.
        play_record(4000, 300, 500, -1, -1, d);
        check("pause_done_at", d, 3500);
        check("pause_pre_high", pw[280], 1);
        check("pause_pwm_zero", pw[400], 0);
        check("pause_busy", bz[400], 1);
        check("pause_idx", ix[400], 0);
        check("pause_resume_low", pw[878], 0);
        check("pause_resume_high", pw[879], 1);

        // Rest first, then seven low-do notes (H=186); no end marker anywhere.
        wr(0, 8'h00);
        for (int a = 1; a < DEPTH; a++) wr(a, 8'h01);
        play_record(8100, -1, 0, -1, -1, d);
        check("full_done_at", d, 8000);
        check("rest_pwm", pw[500], 0);
        check("rest_playing", pl[500], 0);
        check("rest_busy", bz[500], 1);
        check("low_do_pre", pw[1285], 0);
        check("low_do_high", pw[1286], 1);
        check("last_idx", ix[7999], 7);

        // Write and start while busy are both ignored.
        load_basic();
        play_record(4000, -1, 0, -1, 500, d);
        check("busy_wr_done_at", d, 3000);
        check("busy_wr_idx", ix[1000], 1);
        check("busy_wr_note1", pw[1183], 1);

        // Asynchronous reset mid-tone, then replay from note 0.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        check("rst_pwm_before", int'(pwm), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pwm_async", int'(pwm), 0);
        check("rst_busy_async", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        play_record(4000, -1, 0, -1, -1, d);
        check("replay_done_at", d, 3000);
        check("replay_idx0", ix[500], 0);
        check("replay_note1", pw[1183], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 SHALL have parameter DEPTH, default 64, melody memory entries (power of two, >=4); AW = log2(DEPTH) derived.
REQ-002 SHALL have parameter UNIT_CYC, default 12_500_000, clock cycles per duration unit (0.125 s at 100 MHz).
REQ-003 SHALL have parameter GAP_CYC, default 2_500_000, silent articulation cycles at each note start; UNIT_CYC > GAP_CYC >= 1.
REQ-004 SHALL have parameter TONE_SHIFT, default 0, right-shift applied to every half-period table value.
REQ-005 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: wr_en  in  1; wr_addr  in  AW; wr_data  in  8 (melody memory write).
REQ-008 SHALL have ports: start  in  1  pulse; stop  in  1  pulse; pause  in  1  level; loop_en  in  1  level.
REQ-009 SHALL have ports: pwm  out  1; busy  out  1; playing  out  1; note_idx  out  AW; done  out  1 (one-cycle pulse).

Function
REQ-010 Entry format SHALL be {dur[7:6], reserved[5], note[4:0]}; played length = UNIT_CYC << dur (1, 2, 4, 8 units).
REQ-011 note 1-7 SHALL select low do..si, 8-14 mid do..si, 15-21 high do..si; 0 and 22-30 SHALL be rests; 31 SHALL be end marker.
REQ-012 Base half-periods SHALL be: low 190840,170068,151515,143266,127551,113636,101215; mid 95602,85179,75873,71633,63776,56818,50607; high 47801,42590,37937,35817,31888,28409,25304. Effective H = base >> TONE_SHIFT, H >= 1.
REQ-013 Memory SHALL be a DEPTH x 8 register array, asynchronous read, not reset; a write SHALL take effect the cycle after wr_en sampled high.
REQ-014 Writes SHALL be accepted only in IDLE; wr_en while busy=1 SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, GAP, TONE, PAUSED; busy=1 in all states except IDLE.
REQ-016 IDLE + start (stop=0): note_idx<=0; if entry 0 is end marker -> stay IDLE, done pulse; else -> GAP next cycle.
REQ-017 GAP SHALL last exactly GAP_CYC cycles with pwm=0, playing=0, then -> TONE.
REQ-018 TONE SHALL last (UNIT_CYC << dur) - GAP_CYC cycles; playing=1 for tone notes, 0 for rests.
REQ-019 End of TONE: next = note_idx+1; if note_idx = DEPTH-1 or entry[next] note = 31 -> wrap to 0 and GAP when loop_en=1, else -> IDLE with done=1 for one cycle; otherwise note_idx<=next, -> GAP.
REQ-020 Tone generator: counter restarts at 0 and pwm=0 on TONE entry; pwm SHALL toggle every H cycles (period 2H), first toggle H cycles after TONE entry.
REQ-021 pwm SHALL be 0 in IDLE, GAP, PAUSED and during rests.
REQ-022 pause=1 in GAP/TONE SHALL -> PAUSED next cycle, freezing duration counter, tone counter and note_idx, pwm forced 0; pause=0 SHALL return to the frozen state with counters resumed; pause ignored in IDLE.
REQ-023 stop SHALL, from any non-IDLE state, -> IDLE next cycle, pwm=0, note_idx<=0, no done pulse; stop has priority over start, pause and end-of-note.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 loop_en SHALL be sampled only at end of the last note.
REQ-026 Duration arithmetic SHALL use a 32-bit counter; no overflow for dur=3 at default parameters.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, pwm=0, busy=0, playing=0, done=0, note_idx=0, all counters 0; memory contents retained.
REQ-028 Release of rst_n SHALL take effect on next clk edge; start in that same cycle SHALL be honored.

Verification (DEPTH=8, UNIT_CYC=1000, GAP_CYC=100, TONE_SHIFT=10)
REQ-029 Write {00,0,8},{01,0,9},{00,0,31}; start -> 100 cycles silence, 900 cycles pwm period 186 (H=93), 100 silence, 1900 cycles period 166 (H=83), then done pulse, busy=0.
REQ-030 Same melody, loop_en=1 -> after note 1 note_idx returns to 0, no done, playing resumes; stop -> IDLE next cycle, pwm=0, no done.
REQ-031 pause=1 for 500 cycles mid-TONE of note 8 -> pwm=0 throughout, total TONE time extends by exactly 500 cycles, phase resumes.
REQ-032 Entry {00,0,0} rest -> 1000 cycles with pwm=0, playing=0, busy=1; all 8 entries non-31 -> done after note_idx=7.
REQ-033 wr_en during playback -> memory unchanged; start while busy -> ignored; rst_n low mid-TONE -> pwm=0 immediately, memory intact, restart replays from note 0.
